// File: rtl/dm_pkg.sv
// dm_pkg: DMOp opcodes, access FSM states and opcode-class helpers for the data-memory access unit
package dm_pkg;
  localparam logic [2:0] DM_LW  = 3'd0;
  localparam logic [2:0] DM_LH  = 3'd1;
  localparam logic [2:0] DM_LHU = 3'd2;
  localparam logic [2:0] DM_LB  = 3'd3;
  localparam logic [2:0] DM_LBU = 3'd4;
  localparam logic [2:0] DM_SW  = 3'd5;
  localparam logic [2:0] DM_SH  = 3'd6;
  localparam logic [2:0] DM_SB  = 3'd7;
  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, RESP} state_e;
  function automatic logic is_store(input logic [2:0] op);
    return op >= DM_SW;
  endfunction
  function automatic logic is_half(input logic [2:0] op);
    return op == DM_LH || op == DM_LHU || op == DM_SH;
  endfunction
  function automatic logic is_byte(input logic [2:0] op);
    return op == DM_LB || op == DM_LBU || op == DM_SB;
  endfunction
  function automatic logic is_signed(input logic [2:0] op);
    return op == DM_LB || op == DM_LH;
  endfunction
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    return is_half(op) ? a[0] : !is_byte(op) && a != 2'd0;
  endfunction
endpackage

// File: rtl/dm_lane_unit.sv
// dm_lane_unit: little-endian byte/half lane extraction for loads and lane merge for sub-word stores
// Ports: op (DMOp), lane (addr[1:0]), word (SRAM word), wdata (store data)
//        load (extended load value), merged (word with addressed lane replaced; wdata for SW)
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load,
  output logic [31:0] merged
);
  logic [4:0]  sh;
  logic [7:0]  b;
  logic [15:0] h;
  logic        sg;
  always_comb begin
    sh = {lane, 3'b000};
    b = 8'(word >> sh);
    h = lane[1] ? word[31:16] : word[15:0];
    sg = is_signed(op);
    load = is_byte(op) ? {{24{sg & b[7]}}, b} : is_half(op) ? {{16{sg & h[15]}}, h} : word;
    merged = is_byte(op) ? (word & ~(32'hFF << sh)) | ({24'd0, wdata[7:0]} << sh) :
             is_half(op) ? (lane[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]}) :
             wdata;
  end
endmodule

// File: rtl/dm_access_unit.sv
// dm_access_unit: multi-cycle LW/LH/LHU/LB/LBU/SW/SH/SB engine over a byte-enable-less synchronous SRAM
// Ports: clk, rstn (async active-low); core side req/dm_op/addr/wdata in, ready/done/rdata/err out;
//        SRAM side mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in (one-cycle read latency)
module dm_access_unit
  import dm_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req,
  input  logic [2:0]    dm_op,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic          ready,
  output logic          done,
  output logic [31:0]   rdata,
  output logic          err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);
  state_e        state, nxt;
  logic [2:0]    op_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q, merge_q, ld, mg;
  logic          unused_addr;
  // Address bits above the SRAM word index are dropped, so accesses wrap modulo the depth.
  assign unused_addr = ^addr[31:AW+2];
  dm_lane_unit u_lane (
    .op(op_q),
    .lane(addr_q[1:0]),
    .word(mem_rdata),
    .wdata(wdata_q),
    .load(ld),
    .merged(mg)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !req ? IDLE : misaligned(dm_op, addr[1:0]) ? RESP : dm_op == DM_SW ? WRITE : READ;
      READ:    nxt = MERGE;
      MERGE:   nxt = is_store(op_q) ? WRITE : RESP;
      WRITE:   nxt = RESP;
      default: nxt = IDLE;
    endcase
    ready = state == IDLE;
    done = state == RESP;
    err = state == RESP && misaligned(op_q, addr_q[1:0]);
    mem_en = state == READ || state == WRITE;
    mem_we = state == WRITE;
  end
  assign mem_addr = addr_q[AW+1:2];
  assign mem_wdata = op_q == DM_SW ? wdata_q : merge_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      op_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata <= '0;
    end else begin
      if (ready && req) begin
        op_q <= dm_op;
        addr_q <= addr[AW+1:0];
        wdata_q <= wdata;
      end
      if (state == MERGE && is_store(op_q)) merge_q <= mg;
      if (state == MERGE && !is_store(op_q)) rdata <= ld;
    end
endmodule

// File: tb/tb_dm_access_unit.sv
// tb_dm_access_unit: table, hand-written and randomized checks of dm_access_unit against a byte-array memory model
module tb_dm_access_unit;
  logic        clk, rstn, req;
  logic [2:0]  dm_op;
  logic [31:0] addr, wdata;
  logic        ready, done, err, mem_en, mem_we;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] sram [0:1023];
  logic        pre_we;
  logic [9:0]  pre_a;
  logic [31:0] pre_d;
  int          wr_cnt = 0;
  int          checks = 0, errors = 0;
  logic [7:0]  rm [0:4095];
  logic [31:0] m_rd;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, w;
    logic        pre;
    logic [31:0] pv, er;
    logic        ee;
    int          lat;
    logic        cw;
    logic [31:0] ew;
  } vec_t;
  vec_t tv [12];

  dm_access_unit #(.AW(10)) dut (
    .clk(clk), .rstn(rstn), .req(req), .dm_op(dm_op), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .rdata(rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (pre_we) sram[pre_a] <= pre_d;
    else if (mem_en) begin
      if (mem_we) begin
        sram[mem_addr] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end else mem_rdata <= sram[mem_addr];
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mword(input int i);
    return {rm[4*i+3], rm[4*i+2], rm[4*i+1], rm[4*i]};
  endfunction

  task automatic poke(input int i, input logic [31:0] v);
    @(negedge clk);
    pre_a = 10'(i);
    pre_d = v;
    pre_we = 1;
    for (int k = 0; k < 4; k++) rm[4*i+k] = v[8*k+:8];
    @(negedge clk);
    pre_we = 0;
  endtask

  // Reference: memory as a flat byte array; accesses are n-byte little-endian reads/writes.
  task automatic ref_step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w,
                          output int lat, output int en, output int wr, output logic e);
    int n, ba;
    logic st, sg;
    longint v;
    st = op >= 3'd5;
    n = (op == 3'd0 || op == 3'd5) ? 4 : (op == 3'd1 || op == 3'd2 || op == 3'd6) ? 2 : 1;
    sg = op == 3'd1 || op == 3'd3;
    ba = int'(a[11:0]);
    e = (ba % n) != 0;
    if (e) begin
      lat = 1; en = 0; wr = 0;
    end else if (st) begin
      for (int k = 0; k < n; k++) rm[ba+k] = w[8*k+:8];
      lat = n == 4 ? 2 : 4; en = n == 4 ? 1 : 2; wr = 1;
    end else begin
      v = 0;
      for (int k = 0; k < n; k++) v = v | (longint'(rm[ba+k]) << (8*k));
      if (sg && v >= (longint'(1) << (8*n-1))) v = v - (longint'(1) << (8*n));
      m_rd = v[31:0];
      lat = 3; en = 1; wr = 0;
    end
  endtask

  task automatic access(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w,
                        output int lat, output logic [31:0] rd, output logic e, output int en, output int wr);
    int n, w0;
    @(negedge clk);
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    dm_op = op; addr = a; wdata = w; req = 1;
    @(posedge clk);
    #1 req = 0;
    w0 = wr_cnt;
    lat = 0; en = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_en) en++;
      if (done) break;
    end
    rd = rdata; e = err; wr = wr_cnt - w0;
  endtask

  task automatic run_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w, input string tag);
    int lat, en, wr, xl, xe, xw;
    logic [31:0] rd;
    logic e, xer;
    access(op, a, w, lat, rd, e, en, wr);
    ref_step(op, a, w, xl, xe, xw, xer);
    chk({tag, " latency"}, lat, xl);
    chk({tag, " err"}, {31'd0, e}, {31'd0, xer});
    chk({tag, " rdata"}, rd, m_rd);
    chk({tag, " writes"}, wr, xw);
    chk({tag, " en_cycles"}, en, xe);
    if (op >= 3'd5) chk({tag, " sram_word"}, sram[a[11:2]], mword(int'(a[11:2])));
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w,
                              input logic pre, input logic [31:0] pv, input logic [31:0] er,
                              input logic ee, input int lat, input logic cw, input logic [31:0] ew);
    vec_t t;
    t.op = op; t.a = a; t.w = w; t.pre = pre; t.pv = pv; t.er = er;
    t.ee = ee; t.lat = lat; t.cw = cw; t.ew = ew;
    return t;
  endfunction

  initial begin
    int lat, en, wr, xl, xe, xw, acc, dn, enc, bad, w0, n;
    logic [31:0] rd, a;
    logic e, xer, seen;
    rstn = 0; req = 0; dm_op = 0; addr = 0; wdata = 0; pre_we = 0; pre_a = 0; pre_d = 0;
    m_rd = 0;
    repeat (3) @(negedge clk);
    rstn = 1;
    @(negedge clk);
    chk("reset ready", {31'd0, ready}, 32'd1);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    chk("reset mem_en_we", {30'd0, mem_en, mem_we}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    for (int i = 0; i < 1024; i++) poke(i, $urandom);

    tv[0]  = mk(3'd5, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 0, 2, 1, 32'hDEADBEEF);
    tv[1]  = mk(3'd0, 32'h10, 32'h0, 0, 0, 32'hDEADBEEF, 0, 3, 0, 0);
    tv[2]  = mk(3'd3, 32'h13, 32'h0, 1, 32'h80FF7F01, 32'hFFFFFF80, 0, 3, 0, 0);
    tv[3]  = mk(3'd4, 32'h13, 32'h0, 0, 0, 32'h00000080, 0, 3, 0, 0);
    tv[4]  = mk(3'd3, 32'h10, 32'h0, 0, 0, 32'h00000001, 0, 3, 0, 0);
    tv[5]  = mk(3'd1, 32'h12, 32'h0, 0, 0, 32'hFFFF80FF, 0, 3, 0, 0);
    tv[6]  = mk(3'd2, 32'h12, 32'h0, 0, 0, 32'h000080FF, 0, 3, 0, 0);
    tv[7]  = mk(3'd7, 32'h11, 32'hAA, 1, 32'h11223344, 32'h000080FF, 0, 4, 1, 32'h1122AA44);
    tv[8]  = mk(3'd6, 32'h12, 32'hBEEF, 0, 0, 32'h000080FF, 0, 4, 1, 32'hBEEFAA44);
    tv[9]  = mk(3'd0, 32'h12, 32'h0, 0, 0, 32'h000080FF, 1, 1, 0, 0);
    tv[10] = mk(3'd6, 32'h11, 32'h1234, 0, 0, 32'h000080FF, 1, 1, 1, 32'hBEEFAA44);
    tv[11] = mk(3'd1, 32'h12, 32'h0, 0, 0, 32'hFFFFBEEF, 0, 3, 0, 0);
    for (int i = 0; i < 12; i++) begin
      if (tv[i].pre) poke(int'(tv[i].a[11:2]), tv[i].pv);
      access(tv[i].op, tv[i].a, tv[i].w, lat, rd, e, en, wr);
      ref_step(tv[i].op, tv[i].a, tv[i].w, xl, xe, xw, xer);
      chk($sformatf("vec%0d latency", i), lat, tv[i].lat);
      chk($sformatf("vec%0d err", i), {31'd0, e}, {31'd0, tv[i].ee});
      chk($sformatf("vec%0d rdata", i), rd, tv[i].er);
      chk($sformatf("vec%0d writes", i), wr, xw);
      chk($sformatf("vec%0d en_cycles", i), en, xe);
      if (tv[i].cw) chk($sformatf("vec%0d sram_word", i), sram[tv[i].a[11:2]], tv[i].ew);
    end

    @(negedge clk);
    dm_op = 3'd0; addr = 32'h00001010; wdata = 0; req = 1;
    acc = 0; dn = 0; enc = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      acc += int'(ready);
      dn += int'(done);
      enc += int'(mem_en);
      if (mem_en && mem_addr != 10'd4) bad++;
      if (ready && mem_en) bad++;
      if (i < 15) @(negedge clk);
    end
    req = 0;
    ref_step(3'd0, 32'h00001010, 32'h0, xl, xe, xw, xer);
    chk("held_req accepts", acc, 4);
    chk("held_req dones", dn, 4);
    chk("held_req en_cycles", enc, 4);
    chk("held_req bad_cycles", bad, 0);
    chk("held_req rdata", rdata, m_rd);

    poke(5, 32'h01020304);
    @(negedge clk);
    dm_op = 3'd7; addr = 32'h15; wdata = 32'hFF; req = 1;
    @(posedge clk);
    #1 req = 0;
    n = 0; seen = 0;
    while (n < 10 && !seen) begin
      @(negedge clk);
      n++;
      seen = mem_we;
    end
    chk("rst_rmw reached_write", {31'd0, seen}, 32'd1);
    w0 = wr_cnt;
    rstn = 0;
    #1;
    chk("rst_rmw mem_en_we", {30'd0, mem_en, mem_we}, 32'd0);
    chk("rst_rmw done_err", {30'd0, done, err}, 32'd0);
    chk("rst_rmw rdata", rdata, 32'd0);
    chk("rst_rmw mem_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_rmw mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rstn = 1;
    m_rd = 0;
    @(negedge clk);
    chk("rst_rmw ready", {31'd0, ready}, 32'd1);
    chk("rst_rmw sram_word", sram[5], 32'h01020304);
    chk("rst_rmw writes", wr_cnt - w0, 0);
    run_model(3'd0, 32'h14, 32'h0, "post_reset_lw");

    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'd0;
      if ($urandom_range(0, 1) == 1) a[11:6] = 6'd0;
      run_model(3'($urandom_range(0, 7)), a, $urandom, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
Multi-cycle data-memory access engine that executes the 3-bit DMOp memory opcode produced by the instruction decoder. It handles LW/LH/LHU/LB/LBU/SW/SH/SB against a word-wide synchronous SRAM that has no byte enables. Sub-word stores are done as read-modify-write. It sits between the core's memory stage, which uses a req/ready/done handshake, and the data SRAM.

Parameters:
AW, 10, SRAM word-address width (depth 2^AW words)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
req  in  1  access request, sampled only when ready=1
dm_op  in  3  DMOp: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
addr  in  32  byte address
wdata  in  32  store data (SH uses [15:0], SB uses [7:0])
ready  out  1  unit idle, accepts req this cycle
done  out  1  one-cycle completion pulse
rdata  out  32  load result, valid with done
err  out  1  misalignment flag, valid with done
mem_en  out  1  SRAM enable
mem_we  out  1  SRAM write enable
mem_addr  out  AW  SRAM word index = addr[AW+1:2]
mem_wdata  out  32  SRAM write data
mem_rdata  in  32  SRAM read data, valid the cycle after mem_en=1, mem_we=0

Behaviour:
- States: IDLE, READ, MERGE, WRITE, RESP. ready=1 only in IDLE. req outside IDLE is ignored, with no queueing.
- Accept (IDLE and req): latch dm_op, addr, wdata.
- Misalignment: a word op with addr[1:0]!=0, or a half op with addr[0]!=0, is misaligned.
- Transitions from IDLE on accept: misaligned -> RESP; SW -> WRITE; everything else -> READ.
- READ: mem_en=1, mem_we=0 -> MERGE.
- MERGE: capture mem_rdata.
  - Loads: register the extracted result -> RESP.
  - SH/SB: register the merged word -> WRITE.
- WRITE: mem_en=1, mem_we=1; mem_wdata is the latched wdata (SW) or the merged word -> RESP.
- RESP: done=1 -> IDLE.
- done latency after the accept edge: misaligned 1 cycle, SW 2, loads 3, SH/SB 4. Back-to-back accesses need ready, so there is no overlap.
- Byte order is little-endian.
  - Byte lane = addr[1:0], data bits [8*lane+7 : 8*lane].
  - Half select: addr[1]=0 -> [15:0], addr[1]=1 -> [31:16].
- Extension: LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
- Merge: only the addressed byte or half is replaced; all other bits keep their SRAM values.
- Address bits above AW+1 are ignored, so the address wraps modulo 2^AW words.
- err=1 only with done, and only for a misaligned access. A misaligned access never asserts mem_en or mem_we, and rdata is unchanged.
- rdata updates only on a completed aligned load and holds between loads. Stores leave rdata unchanged.
- mem_en, mem_we, mem_addr and mem_wdata are decoded from the state and latched registers. mem_en and mem_we are 0 outside READ and WRITE.
- Reset (asserted at any time, including mid-access): state -> IDLE. done, err, mem_en, mem_we = 0. rdata, mem_addr, mem_wdata = 0. Latched fields = 0. An in-flight RMW is abandoned and no partial write is issued.

Decomposition:
- Package dm_pkg holds:
  - DM_LW..DM_SB opcode constants, matching the decoder encoding above.
  - The state encoding.
  - is_store, is_half, is_byte and is_signed helper functions.
- One combinational sub-module, dm_lane_unit. It takes op, addr[1:0], the SRAM word and the store data, and produces the extracted load value and the merged store word.
- The FSM and registers stay in dm_access_unit.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> write of word 4 at cycle 1, done at cycle 2; LW done at cycle 3 with rdata=0xDEADBEEF, err=0.
- Word 4 = 0x80FF7F01; LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LB 0x10 -> 0x00000001; LH 0x12 -> 0xFFFF80FF; LHU 0x12 -> 0x000080FF.
- Word 4 = 0x11223344; SB 0x11 wdata=0xAA -> word becomes 0x1122AA44; SH 0x12 wdata=0xBEEF -> 0xBEEFAA44; done at cycle 4 after accept; exactly one SRAM write per store.
- LW 0x12 and SH 0x11 -> done at cycle 1 with err=1, mem_en never asserted, rdata unchanged; then LH 0x12 -> err=0.
- req held high continuously -> ready low while busy, each access accepted only in IDLE, no duplicate or lost requests; addr=0x00001010 with AW=10 -> mem_addr=4.
- Assert rstn low during the WRITE state of an SB -> mem_we drops immediately, all outputs are 0, SRAM word unchanged; after release ready=1 and the next LW completes normally.
